// File: rtl/spatial_acc_pkg.sv
// Shared constants and drain FSM state type for the 4x4 spatial accumulator array.
package spatial_acc_pkg;

  localparam int unsigned N_PE  = 16;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned SH_W  = 5;
  localparam int unsigned IDX_W = $clog2(N_PE);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/acc_requant.sv
// Requantiser: arithmetic right shift of a signed accumulator, then signed saturation to OUT_W.
module acc_requant
  import spatial_acc_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [SH_W-1:0]  sh,
  output logic [OUT_W-1:0] res_c
);

  logic [SH_W-1:0]         sh_eff;
  logic signed [ACC_W-1:0] shifted;
  logic [ACC_W-OUT_W:0]    upper;

  // Shifts past the accumulator width clamp to ACC_W-1, leaving only the sign.
  always_comb begin
    sh_eff = sh;
    if (32'(sh) >= ACC_W) sh_eff = SH_W'(ACC_W - 1);
    shifted = $signed(acc) >>> sh_eff;
    upper   = shifted[ACC_W-1:OUT_W-1];
    if ((&upper) || !(|upper)) begin
      res_c = shifted[OUT_W-1:0];
    end else if (shifted[ACC_W-1]) begin
      res_c = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res_c = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/spatial_acc_drain.sv
// Readout of the PE accumulator array: snapshot on capture, requantise and stream one result per beat.
module spatial_acc_drain
  import spatial_acc_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PE-1:0][ACC_W-1:0]  acc_in,
  input  logic                        capture,
  input  logic [SH_W-1:0]             shift,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_last,
  output logic                        busy,
  output logic                        overrun
);

  drain_state_t               state_q, state_d;
  logic [N_PE-1:0][ACC_W-1:0] snap_q;
  logic [SH_W-1:0]            sh_q;

  logic                       hs_c, last_hs_c, cap_ok_c;
  logic [IDX_W-1:0]           idx_inc_c;
  logic [ACC_W-1:0]           rq_acc_c;
  logic [SH_W-1:0]            rq_sh_c;
  logic [OUT_W-1:0]           rq_res_c;

  logic                       valid_d, last_d, busy_d, overrun_d;
  logic [IDX_W-1:0]           idx_d;
  logic [OUT_W-1:0]           data_d;

  assign hs_c      = out_valid & out_ready;
  assign last_hs_c = hs_c & out_last;
  // A capture lands when idle, or on the final handshake for a zero-bubble restart.
  assign cap_ok_c  = capture & ((state_q == IDLE) | last_hs_c);
  assign idx_inc_c = out_idx + IDX_W'(1);

  // The requantiser looks one beat ahead so out_data can be registered with the index.
  assign rq_acc_c  = cap_ok_c ? acc_in[0] : snap_q[idx_inc_c];
  assign rq_sh_c   = cap_ok_c ? shift     : sh_q;

  acc_requant u_requant (
    .acc   (rq_acc_c),
    .sh    (rq_sh_c),
    .res_c (rq_res_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (capture) state_d = DRAIN;
      DRAIN: if (last_hs_c && !capture) state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d   = out_valid;
    idx_d     = out_idx;
    data_d    = out_data;
    overrun_d = capture & ~cap_ok_c;
    if (cap_ok_c) begin
      valid_d = 1'b1;
      idx_d   = '0;
      data_d  = rq_res_c;
    end else if (hs_c) begin
      if (out_last) begin
        valid_d = 1'b0;
        idx_d   = '0;
        data_d  = '0;
      end else begin
        idx_d  = idx_inc_c;
        data_d = rq_res_c;
      end
    end
    last_d = valid_d & (idx_d == IDX_W'(N_PE - 1));
    busy_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      snap_q    <= '0;
      sh_q      <= '0;
    end else begin
      out_valid <= valid_d;
      out_idx   <= idx_d;
      out_data  <= data_d;
      out_last  <= last_d;
      busy      <= busy_d;
      overrun   <= overrun_d;
      if (cap_ok_c) begin
        snap_q <= acc_in;
        sh_q   <= shift;
      end
    end
  end

endmodule

// File: tb/tb_spatial_acc_drain.sv
// Directed self-checking bench for spatial_acc_drain.
module tb_spatial_acc_drain;
  import spatial_acc_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [N_PE-1:0][ACC_W-1:0] acc_in;
  logic                       capture;
  logic [SH_W-1:0]            shift;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_W-1:0]           out_data;
  logic [IDX_W-1:0]           out_idx;
  logic                       out_last;
  logic                       busy;
  logic                       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  spatial_acc_drain dut (
    .clk       (clk),
    .rst       (rst),
    .acc_in    (acc_in),
    .capture   (capture),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_ramp(input int mul, input int off);
    for (int i = 0; i < int'(N_PE); i++) acc_in[i] = ACC_W'(i * mul + off);
  endtask

  task automatic start_capture(input int mul, input int off, input logic [SH_W-1:0] sh);
    load_ramp(mul, off);
    shift     = sh;
    capture   = 1'b1;
    step();
    capture   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; capture = 1'b0; shift = '0; out_ready = 1'b0; acc_in = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_idx, out_data, out_last, busy, overrun} !== 24'd0)
      $display("FAIL reset_state: got v=%0b idx=%0d data=%h last=%0b busy=%0b ovr=%0b, want all 0",
               out_valid, out_idx, out_data, out_last, busy, overrun);
    else n_pass++;
    rst = 1'b1;
    load_ramp(3, 1);
    repeat (3) step();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_after_reset: got v=%0b busy=%0b, want 0 0", out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    start_capture(100, 0, 5'd0);
    load_ramp(7, 3);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== IDX_W'(i) || out_data !== OUT_W'(i * 100) ||
          out_last !== (i == 15) || busy !== 1'b1 || overrun !== 1'b0)
        $display("FAIL stream_beat%0d: got v=%0b idx=%0d data=%0d last=%0b busy=%0b, want 1 %0d %0d %0b 1",
                 i, out_valid, out_idx, out_data, out_last, busy, i, i * 100, i == 15);
      else n_pass++;
      step();
    end
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0)
      $display("FAIL stream_idle: got v=%0b busy=%0b last=%0b, want 0 0 0", out_valid, busy, out_last);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int exp_idx = 0;
    int cyc     = 0;
    out_ready = 1'b0;
    start_capture(100, 0, 5'd0);
    load_ramp(1, 999);
    while (exp_idx < 16 && cyc < 200) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== IDX_W'(exp_idx) || out_data !== OUT_W'(exp_idx * 100) ||
          out_last !== (exp_idx == 15) || busy !== 1'b1)
        $display("FAIL bp_beat cyc%0d: got v=%0b idx=%0d data=%0d last=%0b busy=%0b, want 1 %0d %0d %0b 1",
                 cyc, out_valid, out_idx, out_data, out_last, busy, exp_idx, exp_idx * 100, exp_idx == 15);
      else n_pass++;
      out_ready = (cyc % 2 == 0) && ($urandom_range(0, 3) != 0);
      if (out_ready) exp_idx++;
      cyc++;
      step();
    end
    n_checks++;
    if (exp_idx != 16)
      $display("FAIL bp_timeout: got %0d handshakes in %0d cycles, want 16", exp_idx, cyc);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_idle: got v=%0b busy=%0b, want 0 0", out_valid, busy);
    else n_pass++;
    out_ready = 1'b1;
  endtask

  task automatic test_saturation();
    logic [ACC_W-1:0] vals [3][4];
    logic [OUT_W-1:0] exps [3][4];
    logic [SH_W-1:0]  shs  [3];
    vals = '{'{32'h0001_0000, 32'hFFFF_0000, 32'h0000_7FFF, 32'hFFFF_8000},
             '{32'h0000_0100, 32'hFFFF_FFFF, 32'h0008_0000, 32'hFFF7_FFF0},
             '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF}};
    exps = '{'{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000},
             '{16'h0010, 16'hFFFF, 16'h7FFF, 16'h8000},
             '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF}};
    shs  = '{5'd0, 5'd4, 5'd31};
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      acc_in = '0;
      for (int c = 0; c < 4; c++) acc_in[c] = vals[r][c];
      shift   = shs[r];
      capture = 1'b1;
      step();
      capture = 1'b0;
      shift   = 5'd7;
      for (int c = 0; c < 4; c++) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== IDX_W'(c) || out_data !== exps[r][c])
          $display("FAIL sat_r%0d_c%0d: got v=%0b idx=%0d data=%h, want 1 %0d %h",
                   r, c, out_valid, out_idx, out_data, c, exps[r][c]);
        else n_pass++;
        step();
      end
      repeat (12) step();
    end
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL sat_idle: got v=%0b busy=%0b, want 0 0", out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_overrun();
    out_ready = 1'b1;
    start_capture(100, 0, 5'd0);
    for (int j = 0; j < 16; j++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== IDX_W'(j) || out_data !== OUT_W'(j * 100) ||
          overrun !== (j == 6))
        $display("FAIL ovr_beat%0d: got v=%0b idx=%0d data=%0d ovr=%0b, want 1 %0d %0d %0b",
                 j, out_valid, out_idx, out_data, overrun, j, j * 100, j == 6);
      else n_pass++;
      if (j == 5) begin
        capture = 1'b1;
        load_ramp(100, 55);
      end
      if (j == 6) capture = 1'b0;
      step();
    end
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0)
      $display("FAIL ovr_idle: got v=%0b busy=%0b ovr=%0b, want 0 0 0", out_valid, busy, overrun);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    start_capture(100, 0, 5'd0);
    for (int j = 0; j < 16; j++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== IDX_W'(j) || out_data !== OUT_W'(j * 100))
        $display("FAIL b2b_a%0d: got v=%0b idx=%0d data=%0d, want 1 %0d %0d",
                 j, out_valid, out_idx, out_data, j, j * 100);
      else n_pass++;
      if (j == 15) begin
        capture = 1'b1;
        load_ramp(1, 5000);
      end
      step();
    end
    capture = 1'b0;
    for (int j = 0; j < 16; j++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== IDX_W'(j) || out_data !== OUT_W'(5000 + j) ||
          out_last !== (j == 15) || busy !== 1'b1 || overrun !== 1'b0)
        $display("FAIL b2b_b%0d: got v=%0b idx=%0d data=%0d last=%0b busy=%0b ovr=%0b, want 1 %0d %0d %0b 1 0",
                 j, out_valid, out_idx, out_data, out_last, busy, overrun, j, 5000 + j, j == 15);
      else n_pass++;
      step();
    end
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL b2b_idle: got v=%0b busy=%0b, want 0 0", out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    start_capture(100, 0, 5'd0);
    repeat (7) step();
    n_checks++;
    if (out_idx !== IDX_W'(7) || out_data !== OUT_W'(700))
      $display("FAIL arst_pre: got idx=%0d data=%0d, want 7 700", out_idx, out_data);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_idx, out_data, out_last, busy, overrun} !== 24'd0)
      $display("FAIL arst_immediate: got v=%0b idx=%0d data=%h last=%0b busy=%0b ovr=%0b, want all 0",
               out_valid, out_idx, out_data, out_last, busy, overrun);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL arst_idle%0d: got v=%0b busy=%0b, want 0 0", k, out_valid, busy);
      else n_pass++;
    end
    start_capture(10, 0, 5'd0);
    for (int j = 0; j < 16; j++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== IDX_W'(j) || out_data !== OUT_W'(j * 10))
        $display("FAIL arst_drain%0d: got v=%0b idx=%0d data=%0d, want 1 %0d %0d",
                 j, out_valid, out_idx, out_data, j, j * 10);
      else n_pass++;
      step();
    end
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL arst_final_idle: got v=%0b busy=%0b, want 0 0", out_valid, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
